// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack CPU: sequences memory, IR/MDR/PC, operand stack and ALU.
// Define STACK_GUARD_EN to enable stack under/overflow checking with a sticky error state.
module stack_controller #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       stackEmpty,
    input  logic       stackFull,
    output logic       memRead,
    output logic       memWrite,
    output logic       IorD,
    output logic       irWrite,
    output logic       mdrWrite,
    output logic       pcWrite,
    output logic       pcSrc,
    output logic       push,
    output logic       pop,
    output logic       stackSrc,
    output logic       aLoad,
    output logic       bLoad,
    output logic [1:0] aluOp,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_POPB    = 4'd3,
        S_POPA    = 4'd4,
        S_EXEC    = 4'd5,
        S_PUSH_RD = 4'd6,
        S_PUSH_WR = 4'd7,
        S_POP_RD  = 4'd8,
        S_POP_WR  = 4'd9,
        S_JMP     = 4'd10,
        S_JZ      = 4'd11,
        S_ERR     = 4'd12
    } state_t;

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT);

    state_t     state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       last_wait;
    logic       empty_fault;
    logic       full_fault;

`ifdef STACK_GUARD_EN
    assign empty_fault = stackEmpty;
    assign full_fault  = stackFull;
`else
    logic unused_guard;
    assign empty_fault  = 1'b0;
    assign full_fault   = 1'b0;
    assign unused_guard = stackEmpty ^ stackFull;
`endif

    assign last_wait = (wait_cnt_q == LAST_WAIT);
    assign state     = state_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 3'd0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        IorD       = 1'b0;
        irWrite    = 1'b0;
        mdrWrite   = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        stackSrc   = 1'b0;
        aLoad      = 1'b0;
        bLoad      = 1'b0;
        aluOp      = 2'b00;
        error      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                memRead = 1'b1;
                if (last_wait) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    3'b000, 3'b001, 3'b010: state_d = S_POPB;
                    3'b011:                 state_d = S_POPA;
                    3'b100:                 state_d = S_PUSH_RD;
                    3'b101:                 state_d = S_POP_RD;
                    3'b110:                 state_d = S_JMP;
                    default:                state_d = S_JZ;
                endcase
                // Stack is still untouched here, so an empty stack can be caught before any strobe.
                if (empty_fault && opcode != 3'b100 && opcode != 3'b110) state_d = S_ERR;
            end
            S_POPB: begin
                if (empty_fault) begin
                    state_d = S_ERR;
                end else begin
                    pop     = 1'b1;
                    bLoad   = 1'b1;
                    state_d = S_POPA;
                end
            end
            S_POPA: begin
                if (empty_fault) begin
                    state_d = S_ERR;
                end else begin
                    pop     = 1'b1;
                    aLoad   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Always preceded by at least one pop, so room for the result is guaranteed.
                aluOp    = opcode[1:0];
                push     = 1'b1;
                stackSrc = 1'b1;
                state_d  = S_FETCH;
            end
            S_PUSH_RD: begin
                memRead = 1'b1;
                IorD    = 1'b1;
                if (last_wait) begin
                    mdrWrite = 1'b1;
                    state_d  = S_PUSH_WR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_PUSH_WR: begin
                if (full_fault) begin
                    state_d = S_ERR;
                end else begin
                    push    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_POP_RD: begin
                if (empty_fault) begin
                    state_d = S_ERR;
                end else begin
                    pop     = 1'b1;
                    aLoad   = 1'b1;
                    state_d = S_POP_WR;
                end
            end
            S_POP_WR: begin
                memWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end
            S_JMP: begin
                pcWrite = 1'b1;
                pcSrc   = 1'b1;
                state_d = S_FETCH;
            end
            S_JZ: begin
                if (empty_fault) begin
                    state_d = S_ERR;
                end else begin
                    pcWrite = zero;
                    pcSrc   = 1'b1;
                    state_d = S_FETCH;
                end
            end
`ifdef STACK_GUARD_EN
            S_ERR: error = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: one instance at MEM_LAT=0 and one at MEM_LAT=2, compared cycle by cycle
// against a phase-level model of each instruction; guard checks run when STACK_GUARD_EN is defined.
module tb_stack_controller;

    // output vector bit positions
    localparam logic [14:0] M_MR   = 15'h4000;
    localparam logic [14:0] M_MW   = 15'h2000;
    localparam logic [14:0] M_IORD = 15'h1000;
    localparam logic [14:0] M_IRW  = 15'h0800;
    localparam logic [14:0] M_MDRW = 15'h0400;
    localparam logic [14:0] M_PCW  = 15'h0200;
    localparam logic [14:0] M_PCS  = 15'h0100;
    localparam logic [14:0] M_PUSH = 15'h0080;
    localparam logic [14:0] M_POP  = 15'h0040;
    localparam logic [14:0] M_SSRC = 15'h0020;
    localparam logic [14:0] M_AL   = 15'h0010;
    localparam logic [14:0] M_BL   = 15'h0008;
    localparam logic [14:0] M_ERR  = 15'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst2, sel2;
    logic [2:0] opcode;
    logic       zero, stackEmpty, stackFull;

    logic memRead0, memWrite0, IorD0, irWrite0, mdrWrite0, pcWrite0, pcSrc0;
    logic push0, pop0, stackSrc0, aLoad0, bLoad0, error0;
    logic [1:0] aluOp0;
    logic [3:0] state0;
    logic memRead2, memWrite2, IorD2, irWrite2, mdrWrite2, pcWrite2, pcSrc2;
    logic push2, pop2, stackSrc2, aLoad2, bLoad2, error2;
    logic [1:0] aluOp2;
    logic [3:0] state2;

    stack_controller #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode), .zero(zero),
        .stackEmpty(stackEmpty), .stackFull(stackFull),
        .memRead(memRead0), .memWrite(memWrite0), .IorD(IorD0), .irWrite(irWrite0),
        .mdrWrite(mdrWrite0), .pcWrite(pcWrite0), .pcSrc(pcSrc0), .push(push0),
        .pop(pop0), .stackSrc(stackSrc0), .aLoad(aLoad0), .bLoad(bLoad0),
        .aluOp(aluOp0), .error(error0), .state(state0)
    );

    stack_controller #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode), .zero(zero),
        .stackEmpty(stackEmpty), .stackFull(stackFull),
        .memRead(memRead2), .memWrite(memWrite2), .IorD(IorD2), .irWrite(irWrite2),
        .mdrWrite(mdrWrite2), .pcWrite(pcWrite2), .pcSrc(pcSrc2), .push(push2),
        .pop(pop2), .stackSrc(stackSrc2), .aLoad(aLoad2), .bLoad(bLoad2),
        .aluOp(aluOp2), .error(error2), .state(state2)
    );

    logic [14:0] out0, out2, act;
    assign out0 = {memRead0, memWrite0, IorD0, irWrite0, mdrWrite0, pcWrite0, pcSrc0,
                   push0, pop0, stackSrc0, aLoad0, bLoad0, aluOp0, error0};
    assign out2 = {memRead2, memWrite2, IorD2, irWrite2, mdrWrite2, pcWrite2, pcSrc2,
                   push2, pop2, stackSrc2, aLoad2, bLoad2, aluOp2, error2};
    assign act  = sel2 ? out2 : out0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", name, got, exp);
        end
    endtask

    function automatic logic [14:0] alu_bits(input logic [2:0] op);
        return {12'd0, op[1:0], 1'b0};
    endfunction

    // Expected output of every cycle of one instruction, from FETCH up to the cycle before the next FETCH.
    task automatic build_expected(input logic [2:0] op, input logic z, input int lat);
        exp_q.delete();
        for (int i = 0; i <= lat; i++) exp_q.push_back(M_MR | ((i == lat) ? (M_IRW | M_PCW) : 15'd0));
        exp_q.push_back(15'd0);
        case (op)
            3'd0, 3'd1, 3'd2: begin
                exp_q.push_back(M_POP | M_BL);
                exp_q.push_back(M_POP | M_AL);
                exp_q.push_back(M_PUSH | M_SSRC | alu_bits(op));
            end
            3'd3: begin
                exp_q.push_back(M_POP | M_AL);
                exp_q.push_back(M_PUSH | M_SSRC | alu_bits(op));
            end
            3'd4: begin
                for (int i = 0; i <= lat; i++)
                    exp_q.push_back(M_MR | M_IORD | ((i == lat) ? M_MDRW : 15'd0));
                exp_q.push_back(M_PUSH);
            end
            3'd5: begin
                exp_q.push_back(M_POP | M_AL);
                exp_q.push_back(M_MW | M_IORD);
            end
            3'd6: exp_q.push_back(M_PCW | M_PCS);
            default: exp_q.push_back((z ? M_PCW : 15'd0) | M_PCS);
        endcase
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input int lat,
                             output logic [14:0] last);
        int c;
        logic [14:0] e;
        build_expected(op, z, lat);
        opcode = op;
        zero   = z;
        c      = 0;
        last   = '0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("lat%0d_op%0d_z%0d_cyc%0d", lat, op, z, c), act, e);
            last = act;
            c++;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        z;
        logic [14:0] last;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] last;
        tbl[0] = '{3'd0, 1'b0, M_PUSH | M_SSRC};
        tbl[1] = '{3'd1, 1'b0, M_PUSH | M_SSRC | 15'h0002};
        tbl[2] = '{3'd2, 1'b1, M_PUSH | M_SSRC | 15'h0004};
        tbl[3] = '{3'd3, 1'b0, M_PUSH | M_SSRC | 15'h0006};
        tbl[4] = '{3'd4, 1'b0, M_PUSH};
        tbl[5] = '{3'd5, 1'b0, M_MW | M_IORD};
        tbl[6] = '{3'd6, 1'b0, M_PCW | M_PCS};
        tbl[7] = '{3'd7, 1'b1, M_PCW | M_PCS};
        tbl[8] = '{3'd7, 1'b0, M_PCS};

        rst0 = 1'b1; rst2 = 1'b1; sel2 = 1'b0;
        opcode = 3'd0; zero = 1'b0; stackEmpty = 1'b0; stackFull = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        check("reset_idle", act, 15'd0);

        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].op, tbl[i].z, 0, last);
            check($sformatf("tbl%0d_last", i), last, tbl[i].last);
        end

        for (int i = 0; i < 40; i++)
            run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, last);

        // reset in POP_RD must abort before POP_WR's write strobe
        opcode = 3'd5;
        @(negedge clk); check("abort_fetch", act, M_MR | M_IRW | M_PCW);
        @(negedge clk); check("abort_decode", act, 15'd0);
        @(negedge clk); check("abort_pop_rd", act, M_POP | M_AL);
        rst0 = 1'b1;
        @(negedge clk); check("abort_no_write", act, 15'd0);
        rst0 = 1'b0;
        run_instr(3'd6, 1'b0, 0, last);

`ifdef STACK_GUARD_EN
        stackEmpty = 1'b1;
        opcode = 3'd5;
        @(negedge clk); check("guard_fetch", act, M_MR | M_IRW | M_PCW);
        @(negedge clk); check("guard_decode", act, 15'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check($sformatf("guard_err%0d", i), act, M_ERR);
        end
        rst0 = 1'b1; stackEmpty = 1'b0;
        @(negedge clk); check("guard_err_reset", act, 15'd0);
        rst0 = 1'b0;
        stackFull = 1'b1;
        opcode = 3'd4;
        @(negedge clk); check("full_fetch", act, M_MR | M_IRW | M_PCW);
        @(negedge clk); check("full_decode", act, 15'd0);
        @(negedge clk); check("full_push_rd", act, M_MR | M_IORD | M_MDRW);
        @(negedge clk); check("full_push_wr_gated", act, 15'd0);
        @(negedge clk); check("full_err", act, M_ERR);
        rst0 = 1'b1; stackFull = 1'b0;
        @(negedge clk); check("full_err_reset", act, 15'd0);
        rst0 = 1'b0;
        run_instr(3'd0, 1'b0, 0, last);
`endif

        rst0 = 1'b1;
        sel2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        check("lat2_reset_idle", act, 15'd0);
        run_instr(3'd4, 1'b0, 2, last);
        check("lat2_push_last", last, M_PUSH);
        run_instr(3'd1, 1'b0, 2, last);
        for (int i = 0; i < 20; i++)
            run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, last);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
